// File: rtl/ht_pkg.sv
// Shared definitions for the VGA frame sink: raster totals, counter sizing,
// the default pixel type and the upstream handshake state encoding.
package ht_pkg;

  localparam int DEF_IMAGE_BITS = 8;

  typedef logic [DEF_IMAGE_BITS-1:0] pixel_t;

  typedef enum logic {
    HS_IDLE = 1'b0,
    HS_ACK  = 1'b1
  } hs_state_t;

  function automatic int h_total(int n, int front, int sync, int back);
    return n + front + sync + back;
  endfunction

  function automatic int v_total(int m, int front, int sync, int back);
    return m + front + sync + back;
  endfunction

  // Bits needed to count 0..total-1; never narrower than one bit.
  function automatic int cnt_width(int total);
    return (total <= 2) ? 1 : $clog2(total);
  endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Raster timing: free-running h/v counters plus combinational decode of the
// active area, active-low syncs, vertical blank and the last-active-pixel strobe.
module vga_timing_gen
  import ht_pkg::*;
#(
  parameter int MATRIX_N = 10,
  parameter int MATRIX_M = 10,
  parameter int H_FRONT  = 2,
  parameter int H_SYNC   = 2,
  parameter int H_BACK   = 2,
  parameter int V_FRONT  = 1,
  parameter int V_SYNC   = 1,
  parameter int V_BACK   = 1,
  parameter int HCW      = 4,
  parameter int VCW      = 4
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  output logic [HCW-1:0] o_h_cnt,
  output logic [VCW-1:0] o_v_cnt,
  output logic           o_active,
  output logic           o_hsync_n,
  output logic           o_vsync_n,
  output logic           o_vblank,
  output logic           o_frame_end
);

  localparam int H_TOTAL = h_total(MATRIX_N, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOTAL = v_total(MATRIX_M, V_FRONT, V_SYNC, V_BACK);

  localparam logic [HCW-1:0] H_LAST     = HCW'(H_TOTAL - 1);
  localparam logic [VCW-1:0] V_LAST     = VCW'(V_TOTAL - 1);
  localparam logic [HCW-1:0] H_ACT_END  = HCW'(MATRIX_N);
  localparam logic [VCW-1:0] V_ACT_END  = VCW'(MATRIX_M);
  localparam logic [HCW-1:0] H_ACT_LAST = HCW'(MATRIX_N - 1);
  localparam logic [VCW-1:0] V_ACT_LAST = VCW'(MATRIX_M - 1);
  localparam logic [HCW-1:0] H_SYNC_BEG = HCW'(MATRIX_N + H_FRONT);
  localparam logic [HCW-1:0] H_SYNC_END = HCW'(MATRIX_N + H_FRONT + H_SYNC);
  localparam logic [VCW-1:0] V_SYNC_BEG = VCW'(MATRIX_M + V_FRONT);
  localparam logic [VCW-1:0] V_SYNC_END = VCW'(MATRIX_M + V_FRONT + V_SYNC);

  logic [HCW-1:0] r_h_cnt;
  logic [VCW-1:0] r_v_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (r_h_cnt == H_LAST) begin
      r_h_cnt <= '0;
      r_v_cnt <= (r_v_cnt == V_LAST) ? '0 : r_v_cnt + 1'b1;
    end else begin
      r_h_cnt <= r_h_cnt + 1'b1;
    end
  end

  assign o_h_cnt     = r_h_cnt;
  assign o_v_cnt     = r_v_cnt;
  assign o_active    = (r_h_cnt < H_ACT_END) && (r_v_cnt < V_ACT_END);
  assign o_hsync_n   = !((r_h_cnt >= H_SYNC_BEG) && (r_h_cnt < H_SYNC_END));
  assign o_vsync_n   = !((r_v_cnt >= V_SYNC_BEG) && (r_v_cnt < V_SYNC_END));
  assign o_vblank    = (r_v_cnt >= V_ACT_END);
  assign o_frame_end = (r_h_cnt == H_ACT_LAST) && (r_v_cnt == V_ACT_LAST);

endmodule

// File: rtl/vga_frame_sink.sv
// Frame sink: four-phase capture of a flattened frame during vertical blank and
// registered raster output. Define VGA_TEST_PATTERN_EN for a checkerboard before the first frame.
module vga_frame_sink
  import ht_pkg::*;
#(
  parameter int IMAGE_BITS = 8,
  parameter int MATRIX_N   = 10,
  parameter int MATRIX_M   = 10,
  parameter int H_FRONT    = 2,
  parameter int H_SYNC     = 2,
  parameter int H_BACK     = 2,
  parameter int V_FRONT    = 1,
  parameter int V_SYNC     = 1,
  parameter int V_BACK     = 1
) (
  input  logic                                     Clk,
  input  logic                                     Reset,
  input  logic [IMAGE_BITS*MATRIX_N*MATRIX_M-1:0]  ImgMat,
  input  logic                                     ReqIn,
  output logic                                     AckIn,
  output logic [IMAGE_BITS-1:0]                    Pixel,
  output logic                                     HSync,
  output logic                                     VSync,
  output logic                                     DataEn,
  output logic                                     FrameDone,
  output hs_state_t                                DbgHsState
);

  localparam int H_TOTAL = h_total(MATRIX_N, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOTAL = v_total(MATRIX_M, V_FRONT, V_SYNC, V_BACK);
  localparam int HCW     = cnt_width(H_TOTAL);
  localparam int VCW     = cnt_width(V_TOTAL);
  localparam int NPIX    = MATRIX_N * MATRIX_M;
  localparam int PIX_IW  = cnt_width(NPIX);

  logic [HCW-1:0]        w_h_cnt;
  logic [VCW-1:0]        w_v_cnt;
  logic                  w_active;
  logic                  w_hsync_n;
  logic                  w_vsync_n;
  logic                  w_vblank;
  logic                  w_frame_end;
  logic                  w_capture;
  logic [PIX_IW-1:0]     w_pix_idx;
  logic [IMAGE_BITS-1:0] w_pix_next;

  hs_state_t             r_state;
  logic                  r_ack;
  logic                  r_buf_valid;
  logic [IMAGE_BITS-1:0] r_buf [NPIX];
  logic                  r_frame_end_d;
  logic [IMAGE_BITS-1:0] r_pixel;
  logic                  r_hsync;
  logic                  r_vsync;
  logic                  r_data_en;
  logic                  r_frame_done;

  vga_timing_gen #(
    .MATRIX_N (MATRIX_N),
    .MATRIX_M (MATRIX_M),
    .H_FRONT  (H_FRONT),
    .H_SYNC   (H_SYNC),
    .H_BACK   (H_BACK),
    .V_FRONT  (V_FRONT),
    .V_SYNC   (V_SYNC),
    .V_BACK   (V_BACK),
    .HCW      (HCW),
    .VCW      (VCW)
  ) u_timing (
    .i_clk       (Clk),
    .i_rst_n     (Reset),
    .o_h_cnt     (w_h_cnt),
    .o_v_cnt     (w_v_cnt),
    .o_active    (w_active),
    .o_hsync_n   (w_hsync_n),
    .o_vsync_n   (w_vsync_n),
    .o_vblank    (w_vblank),
    .o_frame_end (w_frame_end)
  );

  // Four-phase handshake: upstream raises ReqIn with ImgMat stable; the frame is
  // taken only in vertical blank, then AckIn stays high until ReqIn is seen low.
  assign w_capture = (r_state == HS_IDLE) && ReqIn && w_vblank;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state     <= HS_IDLE;
      r_ack       <= 1'b0;
      r_buf_valid <= 1'b0;
    end else begin
      case (r_state)
        HS_IDLE: begin
          if (w_capture) begin
            r_state     <= HS_ACK;
            r_ack       <= 1'b1;
            r_buf_valid <= 1'b1;
          end
        end
        HS_ACK: begin
          if (!ReqIn) begin
            r_state <= HS_IDLE;
            r_ack   <= 1'b0;
          end
        end
        default: begin
          r_state <= HS_IDLE;
          r_ack   <= 1'b0;
        end
      endcase
    end
  end

  // Frame storage carries no reset; r_buf_valid alone decides whether it is shown.
  always_ff @(posedge Clk) begin
    if (w_capture) begin
      for (int i = 0; i < NPIX; i++) begin
        r_buf[i] <= ImgMat[IMAGE_BITS*i +: IMAGE_BITS];
      end
    end
  end

  always_comb begin
    w_pix_idx  = PIX_IW'(int'(w_v_cnt) * MATRIX_N + int'(w_h_cnt));
    w_pix_next = '0;
    if (w_active) begin
      if (r_buf_valid) begin
        w_pix_next = r_buf[w_pix_idx];
      end
`ifdef VGA_TEST_PATTERN_EN
      else if (w_h_cnt[0] ^ w_v_cnt[0]) begin
        w_pix_next = '1;
      end
`endif
    end
  end

  // Everything below lags the counters by one clock; FrameDone lags one more so
  // it lines up with DataEn falling after the last active pixel.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_pixel       <= '0;
      r_hsync       <= 1'b1;
      r_vsync       <= 1'b1;
      r_data_en     <= 1'b0;
      r_frame_end_d <= 1'b0;
      r_frame_done  <= 1'b0;
    end else begin
      r_pixel       <= w_pix_next;
      r_hsync       <= w_hsync_n;
      r_vsync       <= w_vsync_n;
      r_data_en     <= w_active;
      r_frame_end_d <= w_frame_end;
      r_frame_done  <= r_frame_end_d;
    end
  end

  assign AckIn      = r_ack;
  assign Pixel      = r_pixel;
  assign HSync      = r_hsync;
  assign VSync      = r_vsync;
  assign DataEn     = r_data_en;
  assign FrameDone  = r_frame_done;
  assign DbgHsState = r_state;

endmodule

// File: tb/tb_vga_frame_sink.sv
// Bench for vga_frame_sink: raster/handshake reference model feeding an expected queue,
// scenario tasks comparing every sampled cycle plus directed protocol checks.
module tb_vga_frame_sink;
  import ht_pkg::*;

  localparam int IB    = 8;
  localparam int N     = 10;
  localparam int M     = 10;
  localparam int HF    = 2;
  localparam int HS    = 2;
  localparam int HB    = 2;
  localparam int VF    = 1;
  localparam int VS    = 1;
  localparam int VB    = 1;
  localparam int HT    = N + HF + HS + HB;
  localparam int VT    = M + VF + VS + VB;
  localparam int FRAME = HT * VT;
  localparam int EW    = 5 + IB;

  logic              Clk = 1'b0;
  logic              Reset = 1'b0;
  logic              ReqIn = 1'b0;
  logic [IB*N*M-1:0] ImgMat = '0;
  logic              AckIn;
  logic [IB-1:0]     Pixel;
  logic              HSync;
  logic              VSync;
  logic              DataEn;
  logic              FrameDone;
  hs_state_t         DbgHsState;

  int errors = 0;
  int checks = 0;
  logic [EW-1:0] exp_q[$];

  int            m_pos;
  bit            m_ack;
  bit            m_valid;
  logic [IB-1:0] m_frame [N*M];

  wire [EW-1:0] obs_vec = {AckIn, FrameDone, DataEn, HSync, VSync, Pixel};

  vga_frame_sink #(
    .IMAGE_BITS (IB), .MATRIX_N (N), .MATRIX_M (M),
    .H_FRONT (HF), .H_SYNC (HS), .H_BACK (HB),
    .V_FRONT (VF), .V_SYNC (VS), .V_BACK (VB)
  ) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .ImgMat     (ImgMat),
    .ReqIn      (ReqIn),
    .AckIn      (AckIn),
    .Pixel      (Pixel),
    .HSync      (HSync),
    .VSync      (VSync),
    .DataEn     (DataEn),
    .FrameDone  (FrameDone),
    .DbgHsState (DbgHsState)
  );

  // Clock and watchdog.
  always #5 Clk = ~Clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not complete (errors=%0d)", errors);
    $fatal(1, "watchdog expired");
  end

  // Reference model: m_pos is the raster position the outputs will show after
  // this edge; expectations come straight from the raster and protocol rules.
  always @(posedge Clk or negedge Reset) begin : ref_model
    int h;
    int v;
    logic de, hs, vs, fd;
    logic [IB-1:0] pix;
    if (!Reset) begin
      m_pos   = 0;
      m_ack   = 1'b0;
      m_valid = 1'b0;
      exp_q.delete();
    end else begin
      h   = m_pos % HT;
      v   = m_pos / HT;
      de  = (h < N) && (v < M);
      hs  = !((h >= N + HF) && (h < N + HF + HS));
      vs  = !((v >= M + VF) && (v < M + VF + VS));
      fd  = (m_pos == (M - 1) * HT + N);
      pix = '0;
      if (de) begin
        if (m_valid) pix = m_frame[v * N + h];
`ifdef VGA_TEST_PATTERN_EN
        else if (((h ^ v) & 1) != 0) pix = '1;
`endif
      end
      if (!m_ack) begin
        if (ReqIn && v >= M) begin
          for (int i = 0; i < N * M; i++) m_frame[i] = ImgMat[i*IB +: IB];
          m_valid = 1'b1;
          m_ack   = 1'b1;
        end
      end else if (!ReqIn) begin
        m_ack = 1'b0;
      end
      exp_q.push_back({m_ack, fd, de, hs, vs, pix});
      m_pos = (m_pos + 1) % FRAME;
    end
  end

  task automatic fill_random();
    for (int i = 0; i < N * M; i++) ImgMat[i*IB +: IB] = IB'($urandom);
  endtask

  task automatic test_reset();
    #12;
    checks++; if (AckIn !== 1'b0) begin errors++; $display("FAIL reset_ack got=%b want=0", AckIn); end
    checks++; if (Pixel !== '0) begin errors++; $display("FAIL reset_pixel got=%h want=00", Pixel); end
    checks++; if (HSync !== 1'b1) begin errors++; $display("FAIL reset_hsync got=%b want=1", HSync); end
    checks++; if (VSync !== 1'b1) begin errors++; $display("FAIL reset_vsync got=%b want=1", VSync); end
    checks++; if (DataEn !== 1'b0) begin errors++; $display("FAIL reset_de got=%b want=0", DataEn); end
    checks++; if (FrameDone !== 1'b0) begin errors++; $display("FAIL reset_fd got=%b want=0", FrameDone); end
    checks++; if (DbgHsState !== HS_IDLE) begin errors++; $display("FAIL reset_state got=%b want=%b", DbgHsState, HS_IDLE); end
    @(negedge Clk); #2 Reset = 1'b1;
  endtask

  task automatic test_idle_timing();
    logic [EW-1:0] exp;
    int hs_low = 0, vs_low = 0, de_high = 0, fd_cnt = 0;
    repeat (2 * FRAME) begin
      @(negedge Clk);
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      checks++;
      if (obs_vec !== exp) begin errors++; $display("FAIL idle_stream pos=%0d got=%h want=%h", m_pos, obs_vec, exp); end
      if (!HSync) hs_low++;
      if (!VSync) vs_low++;
      if (DataEn) de_high++;
      if (FrameDone) fd_cnt++;
    end
    checks++; if (hs_low != 2 * 2 * VT) begin errors++; $display("FAIL idle_hsync_low got=%0d want=%0d", hs_low, 4 * VT); end
    checks++; if (vs_low != 2 * HT) begin errors++; $display("FAIL idle_vsync_low got=%0d want=%0d", vs_low, 2 * HT); end
    checks++; if (de_high != 2 * N * M) begin errors++; $display("FAIL idle_de_high got=%0d want=%0d", de_high, 2 * N * M); end
    checks++; if (fd_cnt != 2) begin errors++; $display("FAIL idle_framedone got=%0d want=2", fd_cnt); end
  endtask

  task automatic test_capture();
    logic [EW-1:0] exp;
    logic [IB-1:0] got [N*M];
    int n = 0, got_n = 0, fd_cnt = 0;
    bit bad0 = 0, bad9 = 0;
    while (m_pos != 11 * HT && n <= FRAME) begin
      @(negedge Clk);
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      checks++;
      if (obs_vec !== exp) begin errors++; $display("FAIL capture_stream pos=%0d got=%h want=%h", m_pos, obs_vec, exp); end
      n++;
    end
    for (int i = 0; i < N * M; i++) ImgMat[i*IB +: IB] = IB'(i);
    ReqIn = 1'b1;
    @(negedge Clk);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    checks++;
    if (obs_vec !== exp) begin errors++; $display("FAIL capture_stream pos=%0d got=%h want=%h", m_pos, obs_vec, exp); end
    checks++; if (AckIn !== 1'b1) begin errors++; $display("FAIL capture_ack_latency got=%b want=1", AckIn); end
    ReqIn = 1'b0;
    repeat (FRAME) begin
      @(negedge Clk);
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      checks++;
      if (obs_vec !== exp) begin errors++; $display("FAIL capture_stream pos=%0d got=%h want=%h", m_pos, obs_vec, exp); end
      if (DataEn && got_n < N * M) begin got[got_n] = Pixel; got_n++; end
      if (FrameDone) fd_cnt++;
    end
    for (int x = 0; x < N; x++) begin
      if (got[x] !== IB'(x)) bad0 = 1;
      if (got[90 + x] !== IB'(90 + x)) bad9 = 1;
    end
    checks++; if (got_n != N * M) begin errors++; $display("FAIL capture_pixel_count got=%0d want=%0d", got_n, N * M); end
    checks++; if (bad0) begin errors++; $display("FAIL capture_line0 got=%h..%h want=00..09", got[0], got[9]); end
    checks++; if (bad9) begin errors++; $display("FAIL capture_line9 got=%h..%h want=5a..63", got[90], got[99]); end
    checks++; if (fd_cnt != 1) begin errors++; $display("FAIL capture_framedone got=%0d want=1", fd_cnt); end
  endtask

  task automatic test_blank_wait();
    logic [EW-1:0] exp;
    int n = 0;
    while (m_pos != 2 * HT + 5 && n <= FRAME) begin
      @(negedge Clk);
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      checks++;
      if (obs_vec !== exp) begin errors++; $display("FAIL blank_stream pos=%0d got=%h want=%h", m_pos, obs_vec, exp); end
      n++;
    end
    fill_random();
    ReqIn = 1'b1;
    n = 0;
    do begin
      @(negedge Clk);
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      checks++;
      if (obs_vec !== exp) begin errors++; $display("FAIL blank_stream pos=%0d got=%h want=%h", m_pos, obs_vec, exp); end
      n++;
    end while (AckIn !== 1'b1 && n < 2 * FRAME);
    checks++;
    if (n != M * HT - (2 * HT + 5) + 1) begin errors++; $display("FAIL blank_ack_wait got=%0d want=%0d", n, M * HT - (2 * HT + 5) + 1); end
  endtask

  task automatic test_back_to_back();
    logic [EW-1:0] exp;
    int n = 0;
    fill_random();
    repeat (FRAME) begin
      @(negedge Clk);
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      checks++;
      if (obs_vec !== exp) begin errors++; $display("FAIL b2b_stream pos=%0d got=%h want=%h", m_pos, obs_vec, exp); end
    end
    checks++; if (AckIn !== 1'b1) begin errors++; $display("FAIL b2b_ack_held got=%b want=1", AckIn); end
    ReqIn = 1'b0;
    repeat (2) begin
      @(negedge Clk);
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      checks++;
      if (obs_vec !== exp) begin errors++; $display("FAIL b2b_stream pos=%0d got=%h want=%h", m_pos, obs_vec, exp); end
    end
    checks++; if (AckIn !== 1'b0) begin errors++; $display("FAIL b2b_ack_drop got=%b want=0", AckIn); end
    ReqIn = 1'b1;
    while (AckIn !== 1'b1 && n < FRAME + 2) begin
      @(negedge Clk);
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      checks++;
      if (obs_vec !== exp) begin errors++; $display("FAIL b2b_stream pos=%0d got=%h want=%h", m_pos, obs_vec, exp); end
      n++;
    end
    checks++; if (AckIn !== 1'b1) begin errors++; $display("FAIL b2b_recapture got=%b want=1", AckIn); end
    ReqIn = 1'b0;
    repeat (FRAME + HT) begin
      @(negedge Clk);
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      checks++;
      if (obs_vec !== exp) begin errors++; $display("FAIL b2b_stream pos=%0d got=%h want=%h", m_pos, obs_vec, exp); end
    end
  endtask

  task automatic test_reset_mid();
    logic [EW-1:0] exp;
    int n = 0, ack_cnt = 0;
    fill_random();
    ReqIn = 1'b1;
    while ((AckIn !== 1'b1 || m_pos % HT != 4 || m_pos / HT >= M) && n < 3 * FRAME) begin
      @(negedge Clk);
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      checks++;
      if (obs_vec !== exp) begin errors++; $display("FAIL rstmid_stream pos=%0d got=%h want=%h", m_pos, obs_vec, exp); end
      n++;
    end
    checks++; if (AckIn !== 1'b1) begin errors++; $display("FAIL rstmid_ack_before got=%b want=1", AckIn); end
    #2 Reset = 1'b0; ReqIn = 1'b0;
    #1;
    checks++; if (AckIn !== 1'b0) begin errors++; $display("FAIL rstmid_ack got=%b want=0", AckIn); end
    checks++; if (Pixel !== '0) begin errors++; $display("FAIL rstmid_pixel got=%h want=00", Pixel); end
    checks++; if ({HSync, VSync} !== 2'b11) begin errors++; $display("FAIL rstmid_syncs got=%b want=11", {HSync, VSync}); end
    checks++; if ({DataEn, FrameDone} !== 2'b00) begin errors++; $display("FAIL rstmid_de_fd got=%b want=00", {DataEn, FrameDone}); end
    repeat (3) @(negedge Clk);
    #2 Reset = 1'b1;
    repeat (FRAME) begin
      @(negedge Clk);
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      checks++;
      if (obs_vec !== exp) begin errors++; $display("FAIL rstmid_stream pos=%0d got=%h want=%h", m_pos, obs_vec, exp); end
      if (AckIn) ack_cnt++;
    end
    checks++; if (ack_cnt != 0) begin errors++; $display("FAIL rstmid_no_ack got=%0d want=0", ack_cnt); end
  endtask

  task automatic test_req_pulse();
    logic [EW-1:0] exp;
    int n = 0, ack_cnt = 0;
    int target = $urandom_range(0, M * HT - 1);
    fill_random();
    while (m_pos != target && n <= FRAME) begin
      @(negedge Clk);
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      checks++;
      if (obs_vec !== exp) begin errors++; $display("FAIL pulse_stream pos=%0d got=%h want=%h", m_pos, obs_vec, exp); end
      n++;
    end
    ReqIn = 1'b1;
    @(negedge Clk);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    checks++;
    if (obs_vec !== exp) begin errors++; $display("FAIL pulse_stream pos=%0d got=%h want=%h", m_pos, obs_vec, exp); end
    ReqIn = 1'b0;
    repeat (2 * FRAME) begin
      @(negedge Clk);
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      checks++;
      if (obs_vec !== exp) begin errors++; $display("FAIL pulse_stream pos=%0d got=%h want=%h", m_pos, obs_vec, exp); end
      if (AckIn) ack_cnt++;
    end
    checks++; if (ack_cnt != 0) begin errors++; $display("FAIL pulse_no_ack got=%0d want=0", ack_cnt); end
  endtask

  task automatic test_random_frames();
    logic [EW-1:0] exp;
    int n;
    repeat (6) begin
      fill_random();
      repeat ($urandom_range(0, FRAME - 1)) begin
        @(negedge Clk);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        checks++;
        if (obs_vec !== exp) begin errors++; $display("FAIL random_stream pos=%0d got=%h want=%h", m_pos, obs_vec, exp); end
      end
      ReqIn = 1'b1;
      n = 0;
      while (AckIn !== 1'b1 && n < M * HT + 1 + HT) begin
        @(negedge Clk);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        checks++;
        if (obs_vec !== exp) begin errors++; $display("FAIL random_stream pos=%0d got=%h want=%h", m_pos, obs_vec, exp); end
        n++;
      end
      checks++; if (AckIn !== 1'b1) begin errors++; $display("FAIL random_ack_timeout got=%b want=1", AckIn); end
      repeat ($urandom_range(0, 4)) begin
        @(negedge Clk);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        checks++;
        if (obs_vec !== exp) begin errors++; $display("FAIL random_stream pos=%0d got=%h want=%h", m_pos, obs_vec, exp); end
      end
      ReqIn = 1'b0;
    end
    repeat (FRAME + HT) begin
      @(negedge Clk);
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      checks++;
      if (obs_vec !== exp) begin errors++; $display("FAIL random_stream pos=%0d got=%h want=%h", m_pos, obs_vec, exp); end
    end
  endtask

  initial begin
    test_reset();
    test_idle_timing();
    test_capture();
    test_blank_wait();
    test_back_to_back();
    test_reset_mid();
    test_req_pulse();
    test_random_frames();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
